// File: rtl/bp_me_pkg.sv
// Shared helpers for the memory-endpoint link blocks.
package bp_me_pkg;

   // Width of a link index; a single link still needs one bit.
   function automatic int link_id_width(input int num_links);
      return (num_links > 1) ? $clog2(num_links) : 1;
   endfunction

endpackage

// File: rtl/bp_me_rr_pick.sv
// Rotating priority encoder: the first requester at or after the pointer wins.
module bp_me_rr_pick
   import bp_me_pkg::*;
#(
   parameter int num_links_p = 4,
   localparam int lid_w = link_id_width(num_links_p)
) (
   input  logic [num_links_p-1:0] req,
   input  logic [lid_w-1:0]       rr,
   output logic [num_links_p-1:0] grant,
   output logic [lid_w-1:0]       id,
   output logic                   v
);

   int idx;

   always_comb begin
      grant = '0;
      id    = '0;
      v     = 1'b0;
      idx   = 0;
      for (int k = 0; k < num_links_p; k++) begin
         idx = int'(rr) + k;
         if (idx >= num_links_p) idx = idx - num_links_p;
         if (!v && req[idx]) begin
            v          = 1'b1;
            grant[idx] = 1'b1;
            id         = lid_w'(idx);
         end
      end
   end

endmodule

// File: rtl/bp_me_wormhole_link_arbiter.sv
// Packet-atomic round-robin arbiter folding N ready-and wormhole links onto one.
module bp_me_wormhole_link_arbiter
   import bp_me_pkg::*;
#(
   parameter int num_links_p  = 4,
   parameter int flit_width_p = 64,
   parameter int len_width_p  = 4,
   parameter int len_offset_p = 0,
   localparam int lid_w = link_id_width(num_links_p)
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic [num_links_p-1:0]              in_v_i,
   input  logic [num_links_p*flit_width_p-1:0] in_data_i,
   output logic [num_links_p-1:0]              in_ready_and_o,
   output logic                                out_v_o,
   output logic [flit_width_p-1:0]             out_data_o,
   input  logic                                out_ready_and_i,
   output logic                                busy_o,
   output logic [lid_w-1:0]                    grant_id_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY} state_e;

   state_e                 st, st_n;
   logic [lid_w-1:0]       lock_r, lock_n;
   logic [lid_w-1:0]       rr_r, rr_n;
   logic [len_width_p-1:0] cnt_r, cnt_n;

   logic [num_links_p-1:0] pick_grant;
   logic [lid_w-1:0]       pick_id;
   logic                   pick_v;

   logic [lid_w-1:0]       sel;
   logic [num_links_p-1:0] sel_oh;
   logic                   out_v_raw;
   logic                   hs;
   logic [len_width_p-1:0] hdr_len;

   function automatic logic [lid_w-1:0] wrap_inc(input logic [lid_w-1:0] id);
      if (int'(id) >= num_links_p - 1) return '0;
      return id + 1'b1;
   endfunction

   bp_me_rr_pick #(.num_links_p(num_links_p)) u_pick (
      .req   (in_v_i),
      .rr    (rr_r),
      .grant (pick_grant),
      .id    (pick_id),
      .v     (pick_v)
   );

   // Only IDLE searches; once a header has been shown the grant is locked.
   always_comb begin
      sel       = rr_r;
      sel_oh    = '0;
      out_v_raw = 1'b0;
      if (st == ST_IDLE) begin
         sel       = pick_v ? pick_id : rr_r;
         out_v_raw = |in_v_i;
      end else begin
         sel       = lock_r;
         out_v_raw = in_v_i[sel];
      end
      if (st == ST_IDLE && pick_v) begin
         sel_oh = pick_grant;
      end else begin
         for (int i = 0; i < num_links_p; i++) begin
            if (int'(sel) == i) sel_oh[i] = 1'b1;
         end
      end
   end

   // Handshake semantics: a flit moves on a cycle where out_v_o and
   // out_ready_and_i are both high; the granted input sees the downstream
   // ready unmodified, every other input sees 0, and all are 0 in reset.
   always_comb begin
      out_data_o     = in_data_i[sel*flit_width_p +: flit_width_p];
      out_v_o        = reset_n_i & out_v_raw;
      in_ready_and_o = reset_n_i ? (sel_oh & {num_links_p{out_ready_and_i}}) : '0;
      busy_o         = reset_n_i & (st != ST_IDLE);
      grant_id_o     = reset_n_i ? sel : '0;
   end

   assign hs      = out_v_o & out_ready_and_i;
   assign hdr_len = out_data_o[len_offset_p +: len_width_p];

   always_comb begin
      st_n   = st;
      lock_n = lock_r;
      cnt_n  = cnt_r;
      rr_n   = rr_r;
      case (st)
         ST_IDLE, ST_HDR: begin
            if (hs) begin
               if (hdr_len == '0) begin
                  st_n = ST_IDLE;
                  rr_n = wrap_inc(sel);
               end else begin
                  st_n   = ST_BODY;
                  lock_n = sel;
                  cnt_n  = hdr_len;
               end
            end else if (st == ST_IDLE && out_v_o) begin
               // Stalled header stays put; later arrivals cannot preempt it.
               st_n   = ST_HDR;
               lock_n = sel;
            end
         end
         ST_BODY: begin
            if (hs) begin
               cnt_n = cnt_r - 1'b1;
               if (cnt_r == len_width_p'(1)) begin
                  st_n = ST_IDLE;
                  rr_n = wrap_inc(lock_r);
               end
            end
         end
         default: st_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         st     <= ST_IDLE;
         lock_r <= '0;
         cnt_r  <= '0;
         rr_r   <= '0;
      end else begin
         st     <= st_n;
         lock_r <= lock_n;
         cnt_r  <= cnt_n;
         rr_r   <= rr_n;
      end
   end

endmodule

// File: tb/tb_bp_me_wormhole_link_arbiter.sv
// Directed bench for the wormhole link arbiter: a 4-link and a 3-link instance.
module tb_bp_me_wormhole_link_arbiter;

   logic         clk;
   logic         reset_n;
   logic [3:0]   in_v;
   logic [255:0] in_data;
   logic [3:0]   in_ready;
   logic         out_v;
   logic [63:0]  out_data;
   logic         out_ready;
   logic         busy;
   logic [1:0]   grant_id;

   logic         reset3_n;
   logic [2:0]   in_v3;
   logic [191:0] in_data3;
   logic [2:0]   in_ready3;
   logic         out_v3;
   logic [63:0]  out_data3;
   logic         out_ready3;
   logic         busy3;
   logic [1:0]   grant3;

   int total;
   int bad;

   bp_me_wormhole_link_arbiter #(.num_links_p(4)) u_dut (
      .clk_i(clk), .reset_n_i(reset_n), .in_v_i(in_v), .in_data_i(in_data),
      .in_ready_and_o(in_ready), .out_v_o(out_v), .out_data_o(out_data),
      .out_ready_and_i(out_ready), .busy_o(busy), .grant_id_o(grant_id)
   );

   bp_me_wormhole_link_arbiter #(.num_links_p(3)) u_dut3 (
      .clk_i(clk), .reset_n_i(reset3_n), .in_v_i(in_v3), .in_data_i(in_data3),
      .in_ready_and_o(in_ready3), .out_v_o(out_v3), .out_data_o(out_data3),
      .out_ready_and_i(out_ready3), .busy_o(busy3), .grant_id_o(grant3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [63:0] hdr(input int link, input int tag, input int len);
      return {8'(link), 52'(tag), 4'(len)};
   endfunction

   function automatic logic [63:0] body(input int link, input int k);
      return {8'(link), 52'(32'h100 + k), 4'hF};
   endfunction

   task automatic set_link(input int i, input logic [63:0] d);
      in_data[i*64 +: 64] = d;
   endtask

   task automatic set_link3(input int i, input logic [63:0] d);
      in_data3[i*64 +: 64] = d;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_n = 1'b0; reset3_n = 1'b0;
      in_v = 4'hF; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_link(i, hdr(i, 0, 0));
      #1;
      total++; if (out_v !== 1'b0) begin bad++; $display("FAIL reset_out_v: got %b want 0", out_v); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1; reset3_n = 1'b1;
      #1;
      total++; if (out_v !== 1'b1) begin bad++; $display("FAIL release_out_v: got %b want 1", out_v); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL release_grant: got %0d want 0", grant_id); end
      total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL release_in_ready: got %b want 0001", in_ready); end
      in_v = 4'h0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      logic [3:0] exp_r;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_v = 4'hF; out_ready = 1'b1;
         for (int i = 0; i < 4; i++) set_link(i, hdr(i, k, 0));
         exp_g = 2'(k % 4);
         exp_r = 4'b0001 << (k % 4);
         #1;
         total++; if (grant_id !== exp_g) begin bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_id, exp_g); end
         total++; if (out_data !== hdr(k % 4, k, 0)) begin bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, out_data, hdr(k % 4, k, 0)); end
         total++; if (in_ready !== exp_r) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, exp_r); end
      end
      @(negedge clk);
      in_v = 4'h0;
   endtask

   task automatic test_atomic();
      @(negedge clk);
      in_v = 4'b0110; out_ready = 1'b1;
      set_link(1, hdr(1, 1, 3)); set_link(2, hdr(2, 2, 0));
      #1;
      total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL atomic_hdr_grant: got %0d want 1", grant_id); end
      total++; if (out_data !== hdr(1, 1, 3)) begin bad++; $display("FAIL atomic_hdr_data: got %h want %h", out_data, hdr(1, 1, 3)); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL atomic_hdr_busy: got %b want 0", busy); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         set_link(1, body(1, c));
         #1;
         total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL atomic_body_grant[%0d]: got %0d want 1", c, grant_id); end
         total++; if (out_data !== body(1, c)) begin bad++; $display("FAIL atomic_body_data[%0d]: got %h want %h", c, out_data, body(1, c)); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL atomic_body_busy[%0d]: got %b want 1", c, busy); end
         total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL atomic_body_ready[%0d]: got %b want 0010", c, in_ready); end
      end
      @(negedge clk);
      in_v = 4'b0100;
      #1;
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL atomic_next_grant: got %0d want 2", grant_id); end
      total++; if (out_data !== hdr(2, 2, 0)) begin bad++; $display("FAIL atomic_next_data: got %h want %h", out_data, hdr(2, 2, 0)); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL atomic_next_busy: got %b want 0", busy); end
      @(negedge clk);
      in_v = 4'h0;
   endtask

   task automatic test_backpressure();
      // Pointer sits at 3 here; one single-flit packet from link 0 moves it to 1.
      @(negedge clk);
      in_v = 4'b0001; out_ready = 1'b1; set_link(0, hdr(0, 5, 0));
      #1;
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL bp_pre_grant: got %0d want 0", grant_id); end
      @(negedge clk);
      in_v = 4'b0100; out_ready = 1'b0; set_link(2, hdr(2, 6, 0));
      #1;
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL bp_first_grant: got %0d want 2", grant_id); end
      total++; if (out_v !== 1'b1) begin bad++; $display("FAIL bp_first_out_v: got %b want 1", out_v); end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         in_v = 4'b0110; set_link(1, hdr(1, 7, 0));
         #1;
         total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL bp_hold_grant[%0d]: got %0d want 2", c, grant_id); end
         total++; if (out_data !== hdr(2, 6, 0)) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h want %h", c, out_data, hdr(2, 6, 0)); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_hold_busy[%0d]: got %b want 1", c, busy); end
         total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", c, in_ready); end
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
      @(negedge clk);
      in_v = 4'b0010;
      #1;
      total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL bp_after_grant: got %0d want 1", grant_id); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_after_busy: got %b want 0", busy); end
      @(negedge clk);
      in_v = 4'h0;
   endtask

   task automatic test_bubbles();
      @(negedge clk);
      in_v = 4'b1001; out_ready = 1'b1;
      set_link(3, hdr(3, 8, 2)); set_link(0, hdr(0, 9, 0));
      #1;
      total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL bub_hdr_grant: got %0d want 3", grant_id); end
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         in_v = 4'b0001;
         #1;
         total++; if (out_v !== 1'b0) begin bad++; $display("FAIL bub_gap_out_v[%0d]: got %b want 0", c, out_v); end
         total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL bub_gap_ready[%0d]: got %b want 1000", c, in_ready); end
         total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL bub_gap_grant[%0d]: got %0d want 3", c, grant_id); end
      end
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         in_v = 4'b1001; set_link(3, body(3, c));
         #1;
         total++; if (out_data !== body(3, c)) begin bad++; $display("FAIL bub_body_data[%0d]: got %h want %h", c, out_data, body(3, c)); end
         total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL bub_body_ready[%0d]: got %b want 1000", c, in_ready); end
      end
      @(negedge clk);
      in_v = 4'b0001;
      #1;
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL bub_next_grant: got %0d want 0", grant_id); end
      total++; if (out_data !== hdr(0, 9, 0)) begin bad++; $display("FAIL bub_next_data: got %h want %h", out_data, hdr(0, 9, 0)); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bub_next_busy: got %b want 0", busy); end
      @(negedge clk);
      in_v = 4'h0;
   endtask

   task automatic test_wrap_reset();
      logic [2:0] vecs [4];
      logic [1:0] exp_g [4];
      vecs[0] = 3'b001; vecs[1] = 3'b010; vecs[2] = 3'b101; vecs[3] = 3'b101;
      exp_g[0] = 2'd0;  exp_g[1] = 2'd1;  exp_g[2] = 2'd2;  exp_g[3] = 2'd0;
      out_ready3 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_v3 = vecs[k];
         for (int i = 0; i < 3; i++) set_link3(i, hdr(i, 20 + k, 0));
         #1;
         total++; if (grant3 !== exp_g[k]) begin bad++; $display("FAIL wrap_grant[%0d]: got %0d want %0d", k, grant3, exp_g[k]); end
         total++; if (out_data3 !== hdr(exp_g[k], 20 + k, 0)) begin bad++; $display("FAIL wrap_data[%0d]: got %h want %h", k, out_data3, hdr(exp_g[k], 20 + k, 0)); end
      end
      @(negedge clk);
      in_v3 = 3'b010; set_link3(1, hdr(1, 30, 7));
      #1;
      total++; if (grant3 !== 2'd1) begin bad++; $display("FAIL mid_hdr_grant: got %0d want 1", grant3); end
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         set_link3(1, body(1, c));
         #1;
         total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL mid_body_busy[%0d]: got %b want 1", c, busy3); end
      end
      @(negedge clk);
      reset3_n = 1'b0; in_v3 = 3'b111;
      #1;
      total++; if (out_v3 !== 1'b0) begin bad++; $display("FAIL mid_rst_out_v: got %b want 0", out_v3); end
      total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy3); end
      total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL mid_rst_ready: got %b want 000", in_ready3); end
      @(negedge clk);
      reset3_n = 1'b1; in_v3 = 3'b000;
      #1;
      total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", busy3); end
      total++; if (grant3 !== 2'd0) begin bad++; $display("FAIL post_rst_rr: got %0d want 0", grant3); end
      total++; if (out_v3 !== 1'b0) begin bad++; $display("FAIL post_rst_out_v: got %b want 0", out_v3); end
      @(negedge clk);
      in_v3 = 3'b100; set_link3(2, hdr(2, 31, 0));
      #1;
      total++; if (grant3 !== 2'd2) begin bad++; $display("FAIL post_rst_grant: got %0d want 2", grant3); end
      total++; if (out_data3 !== hdr(2, 31, 0)) begin bad++; $display("FAIL post_rst_data: got %h want %h", out_data3, hdr(2, 31, 0)); end
      @(negedge clk);
      in_v3 = 3'b000;
   endtask

   initial begin
      total = 0; bad = 0;
      reset_n = 1'b0; reset3_n = 1'b0;
      in_v = '0; in_data = '0; out_ready = 1'b0;
      in_v3 = '0; in_data3 = '0; out_ready3 = 1'b0;
      test_reset();
      test_round_robin();
      test_atomic();
      test_backpressure();
      test_bubbles();
      test_wrap_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
